mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the 5-stage pipeline. Consumes the EX/MEM pipeline register outputs and resolves branches for the fetch PC mux. Runs a registered request/acknowledge transaction to data memory for loads and stores, stalling the pipeline until the access completes. Produces the aligned, sign- or zero-extended load result for the MEM/WB register.

## Interface
- WAIT_MAX, 255, max REQ cycles without ack before abort; 8-bit counter; 0 disables the timeout.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- alu_MEM  in  32  effective address
- writedata_MEM  in  32  store data, in the low bits
- funct3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- memread_MEM, memwrite_MEM  in  1 each  access type; never both 1
- branch_MEM, zero_MEM, branch_taken_MEM  in  1 each  branch controls
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read word; valid with dmem_ack
- dmem_ack  in  1  completes the request
- stall_MEM  out  1  hazard unit holds PC, IF/ID, ID/EX, EX/MEM
- pcsrc_MEM  out  1  select branch target
- readdata_MEM  out  32  extended load result
- timeout_MEM  out  1  one-cycle pulse on abort
- misalign_MEM  out  1  one-cycle pulse on misaligned access

## Operation
- access = memread_MEM | memwrite_MEM.
- pcsrc_MEM = branch_taken_MEM | (branch_MEM & zero_MEM). Combinational; EX/MEM reset/flush zeroes it.
- FSM states: IDLE, REQ, RESP.
  - IDLE: on access, go to REQ. Register dmem_addr/we/be/wdata and funct3.
  - REQ: dmem_req=1 with all dmem_* held stable. On dmem_ack, capture the aligned load into readdata_MEM and go to RESP. On wait counter = WAIT_MAX (WAIT_MAX≠0) with no ack, pulse timeout_MEM, set readdata_MEM=0, go to RESP.
  - RESP: go to IDLE. The next instruction enters MEM at the end of this cycle.
- stall_MEM = (IDLE & access) | REQ. It is 0 in RESP.
- Stores: B sets be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}. H sets be=4'b0011<<{addr[1],1'b0}, wdata={2{wd[15:0]}}. W sets be=4'hF.
- Loads select the byte/half by addr[1:0], then sign- or zero-extend per funct3. Stores do not modify readdata_MEM.
- Undefined funct3 is treated as W.
- The hazard unit never flushes EX/MEM while stall_MEM=1. This block has no flush input.

## Timing
- Access latency in MEM: 2 cycles + ack wait. An ack in the first REQ cycle gives 3 cycles in MEM.
- dmem_req rises the cycle after the access enters MEM. It falls in the cycle after the ack.
- dmem_ack outside REQ is ignored. An ack on the same cycle as the timeout expiry wins; no timeout pulse.
- readdata_MEM holds its value until the next completed load or timeout.
- Reset values: state IDLE, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, readdata_MEM 0, wait counter 0, timeout_MEM 0, misalign_MEM 0.
- Reset in REQ returns to IDLE with dmem_req 0 the next cycle. A later ack is ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: an H access with addr[0]=1 or a W access with addr[1:0]≠0 issues no request. In IDLE it pulses misalign_MEM for one cycle and goes to RESP; stall is 1 in that cycle only. readdata_MEM is unchanged.
- Undefined: misalign_MEM tied 0. H ignores addr[0] and W ignores addr[1:0] when forming lanes.

## Structure
- Shared package mem_pkg holds: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), the FSM state enum, and WAIT_MAX counter width (8).
- One sub-module, load_align: combinational rdata, addr[1:0], funct3 → 32-bit extended result. The FSM instantiates it at capture.

## Test plan
- LB at 0x1003, ack after 2 REQ cycles, rdata=0x80FF_FF12 → dmem_addr=0x1000, stall_MEM=1 for 3 cycles, readdata_MEM=0xFFFF_FF80.
- SH at 0x2002, wd=0x0000_BEEF, ack in first REQ cycle → be=4'b1100, wdata=0xBEEF_BEEF, dmem_we=1, readdata_MEM unchanged.
- Branch with zero_MEM=1, then branch_taken_MEM=1 with branch_MEM=0 → pcsrc_MEM=1 both times, stall_MEM=0, dmem_req never rises.
- LW with no ack, WAIT_MAX=4 → dmem_req high 4 cycles, timeout_MEM pulses, readdata_MEM=0; ack one cycle later is ignored.
- LHU at 0x3001 with MEM_MISALIGN_TRAP_EN → misalign_MEM=1 for one cycle, dmem_req stays 0. Without the macro: be=4'b0011, result zero-extended from rdata[15:0].
- Reset asserted in the second REQ cycle → dmem_req=0 and state IDLE next cycle, all outputs at reset values, stall_MEM follows the incoming (zeroed) access.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states,
// wait-counter width and store-lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Any encoding that is not a byte or half access behaves as a word.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input size_e sz, input logic [31:0] wd);
    case (sz)
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata_i[7:0];
    case (off_i)
      2'd0: byte_c = rdata_i[7:0];
      2'd1: byte_c = rdata_i[15:8];
      2'd2: byte_c = rdata_i[23:16];
      2'd3: byte_c = rdata_i[31:24];
      default: byte_c = rdata_i[7:0];
    endcase
    half_c = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    result_o = {{24{byte_c[7]}}, byte_c};
      F3_BU:   result_o = {24'b0, byte_c};
      F3_H:    result_o = {{16{half_c[15]}}, half_c};
      F3_HU:   result_o = {16'b0, half_c};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: branch select plus a req/ack data-memory transaction that stalls the pipe.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_MEM,
  input  logic [31:0] writedata_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic        memread_MEM,
  input  logic        memwrite_MEM,
  input  logic        branch_MEM,
  input  logic        zero_MEM,
  input  logic        branch_taken_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_MEM,
  output logic        pcsrc_MEM,
  output logic [31:0] readdata_MEM,
  output logic        timeout_MEM,
  output logic        misalign_MEM
);

  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(WAIT_MAX);
  localparam logic              TIMEOUT_EN = (WAIT_MAX != 0);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        access_c;
  logic        trap_c;
  size_e       size_c;
  logic [31:0] aligned_c;

  assign access_c  = memread_MEM | memwrite_MEM;
  assign size_c    = f3_size(funct3_MEM);
  assign pcsrc_MEM = branch_taken_MEM | (branch_MEM & zero_MEM);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_c = access_c & misaligned(size_c, alu_MEM[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .result_o (aligned_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    off_d        = off_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    f3_d         = f3_q;
    rdata_d      = rdata_q;
    stall_MEM    = 1'b0;
    timeout_MEM  = 1'b0;
    misalign_MEM = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (access_c) begin
          stall_MEM = 1'b1;
          if (trap_c) begin
            misalign_MEM = 1'b1;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_REQ;
            addr_d  = {alu_MEM[31:2], 2'b00};
            off_d   = alu_MEM[1:0];
            we_d    = memwrite_MEM;
            be_d    = store_be(size_c, alu_MEM[1:0]);
            wdata_d = store_wdata(size_c, writedata_MEM);
            f3_d    = funct3_MEM;
            cnt_d   = WAIT_W'(1);
          end
        end
      end

      ST_REQ: begin
        stall_MEM = 1'b1;
        // cnt_q counts REQ cycles including the current one; ack beats expiry.
        if (dmem_ack) begin
          if (!we_q) rdata_d = aligned_c;
          state_d = ST_RESP;
          cnt_d   = '0;
        end else if (TIMEOUT_EN && (cnt_q == WAIT_MAX_C)) begin
          timeout_MEM = 1'b1;
          rdata_d     = '0;
          state_d     = ST_RESP;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_req     = (state_q == ST_REQ);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign readdata_MEM = rdata_q;

endmodule
